mul_acc_stage: RTL and testbench



---
 rtl/mul_acc_stage.sv | 137 +++++++++++++
 tb/tb_mul_acc_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_acc_stage.sv
// Frame accumulator behind the 16x16 Booth multiplier: sums signed products per frame
// and hands the total, term count and overflow flag out over valid/ready. Option: MUL_ACC_SAT_EN.
module mul_acc_stage #(
  parameter int ACC_W     = 40,
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

`ifdef MUL_ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  logic [1:0]       state_r;
  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [ACC_W-1:0] out_acc_r;
  logic [CNT_W-1:0] out_count_r;
  logic             out_ovf_r;

  logic [ACC_W-1:0] base_acc_s;
  logic [CNT_W-1:0] base_cnt_s;
  logic             base_ovf_s;
  logic [ACC_W-1:0] prod_ext_s;
  logic [ACC_W-1:0] sum_s;
  logic             add_ovf_s;
  logic [ACC_W-1:0] acc_next_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             close_s;
  logic             accept_s;

  // Next-term datapath; a first term (IDLE) starts from a zero base so it can never overflow
  always_comb begin
    if (state_r == ACC) begin
      base_acc_s = acc_r;
      base_cnt_s = cnt_r;
      base_ovf_s = ovf_r;
    end else begin
      base_acc_s = {ACC_W{1'b0}};
      base_cnt_s = {CNT_W{1'b0}};
      base_ovf_s = 1'b0;
    end
    prod_ext_s = ACC_W'($signed(in_prod));
    sum_s      = base_acc_s + prod_ext_s;
    add_ovf_s  = (base_acc_s[ACC_W-1] == prod_ext_s[ACC_W-1]) &&
                 (sum_s[ACC_W-1] != base_acc_s[ACC_W-1]);
`ifdef MUL_ACC_SAT_EN
    if (add_ovf_s) begin
      acc_next_s = base_acc_s[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_next_s = sum_s;
    end
`else
    acc_next_s = sum_s;
`endif
    cnt_next_s = base_cnt_s + CNT_W'(1);
    close_s    = in_last || (cnt_next_s == CNT_W'(MAX_TERMS));
    accept_s   = in_valid && in_ready_r;
  end

  // Frame FSM plus accumulator and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_acc_r   <= {ACC_W{1'b0}};
      out_count_r <= {CNT_W{1'b0}};
      out_ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE, ACC: begin
          if (accept_s) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_next_s;
            ovf_r <= base_ovf_s | add_ovf_s;
            if (close_s) begin
              out_acc_r   <= acc_next_s;
              out_count_r <= cnt_next_s;
              out_ovf_r   <= base_ovf_s | add_ovf_s;
              out_valid_r <= 1'b1;
              in_ready_r  <= 1'b0;
              state_r     <= HOLD;
            end else begin
              state_r <= ACC;
            end
          end else begin
            state_r <= state_r;
          end
        end
        HOLD: begin
          if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_acc   = out_acc_r;
  assign out_count = out_count_r;
  assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_mul_acc_stage.sv
// Directed bench for mul_acc_stage: default 40-bit instance plus a 33-bit instance
// for the overflow case (expectation follows MUL_ACC_SAT_EN).
module tb_mul_acc_stage;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
  logic [31:0] in_prod;
  logic [39:0] out_acc;
  logic [4:0]  out_count;

  logic        in_valid2, in_ready2, in_last2, out_valid2, out_ready2, out_ovf2;
  logic [31:0] in_prod2;
  logic [32:0] out_acc2;
  logic [4:0]  out_count2;

  int checks = 0;
  int errors = 0;

  mul_acc_stage #(.ACC_W(40), .MAX_TERMS(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_count(out_count), .out_ovf(out_ovf));

  mul_acc_stage #(.ACC_W(33), .MAX_TERMS(16), .CNT_W(5)) dut33 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_prod(in_prod2),
    .in_last(in_last2), .out_valid(out_valid2), .out_ready(out_ready2), .out_acc(out_acc2),
    .out_count(out_count2), .out_ovf(out_ovf2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic [31:0] p, input logic l);
    @(negedge clk);
    in_valid = 1'b1; in_prod = p; in_last = l;
    @(posedge clk);
  endtask

  task automatic stop_in();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_prod = 32'hDEAD_BEEF;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== 40'd0 ||
        out_count !== 5'd0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b ready=%b acc=%0d cnt=%0d ovf=%b, want 0 1 0 0 0",
               out_valid, in_ready, out_acc, out_count, out_ovf);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    send(32'd100, 1'b0);
    send(-32'sd30, 1'b0);
    stop_in();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_open: valid=%b ready=%b, want 0 1", out_valid, in_ready);
    end
    send(32'd7, 1'b1);
    stop_in();
    checks++;
    if (out_valid !== 1'b1 || out_acc !== 40'd77 || out_count !== 5'd3 ||
        out_ovf !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: valid=%b acc=%0d cnt=%0d ovf=%b ready=%b, want 1 77 3 0 0",
               out_valid, $signed(out_acc), out_count, out_ovf, in_ready);
    end
    handshake();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_release: valid=%b ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_max_terms();
    for (int i = 0; i < 16; i++) begin
      send(32'd1000, 1'b0);
      if (i == 14) begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL max_early_close: valid=%b after 15 terms, want 0", out_valid);
        end
      end
    end
    stop_in();
    checks++;
    if (out_valid !== 1'b1 || out_acc !== 40'd16000 || out_count !== 5'd16 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL max_result: valid=%b acc=%0d cnt=%0d ovf=%b, want 1 16000 16 0",
               out_valid, out_acc, out_count, out_ovf);
    end
    handshake();
  endtask

  task automatic test_stall();
    send(32'd1, 1'b0);
    send(32'd2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      // offer a term during HOLD; it must be refused
      @(negedge clk);
      in_valid = 1'b1; in_prod = 32'd500; in_last = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || out_acc !== 40'd3 || out_count !== 5'd2 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d: valid=%b acc=%0d cnt=%0d ready=%b, want 1 3 2 0",
                 i, out_valid, out_acc, out_count, in_ready);
      end
    end
    stop_in();
    handshake();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: valid=%b ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_frame();
    send(32'd50, 1'b0);
    send(32'd60, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== 40'd0 || out_count !== 5'd0) begin
      errors++;
      $display("FAIL rst_mid: valid=%b ready=%b acc=%0d cnt=%0d, want 0 1 0 0",
               out_valid, in_ready, out_acc, out_count);
    end
    send(32'd5, 1'b0);
    send(32'd6, 1'b1);
    stop_in();
    checks++;
    if (out_valid !== 1'b1 || out_acc !== 40'd11 || out_count !== 5'd2 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL rst_fresh: valid=%b acc=%0d cnt=%0d ovf=%b, want 1 11 2 0",
               out_valid, out_acc, out_count, out_ovf);
    end
    // reset while holding a result, with out_ready high
    out_ready = 1'b1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== 40'd0) begin
      errors++;
      $display("FAIL rst_hold: valid=%b ready=%b acc=%0d, want 0 1 0", out_valid, in_ready, out_acc);
    end
  endtask

  task automatic test_single_term();
    send(32'd1073741824, 1'b1);
    stop_in();
    checks++;
    if (out_valid !== 1'b1 || out_acc !== 40'd1073741824 || out_count !== 5'd1 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL single: valid=%b acc=%0d cnt=%0d ovf=%b, want 1 1073741824 1 0",
               out_valid, out_acc, out_count, out_ovf);
    end
    handshake();
  endtask

  task automatic test_negative();
    send(-32'sd1000, 1'b0);
    send(-32'sd24, 1'b1);
    stop_in();
    checks++;
    if (out_acc !== 40'hFF_FFFF_FC00 || out_count !== 5'd2 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL negative: acc=%h cnt=%0d ovf=%b, want fffffffc00 2 0", out_acc, out_count, out_ovf);
    end
    handshake();
  endtask

  task automatic test_overflow();
    logic [32:0] exp_acc;
`ifdef MUL_ACC_SAT_EN
    exp_acc = 33'h0_FFFF_FFFF;
`else
    exp_acc = 33'h1_7FFF_FFFD;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid2 = 1'b1; in_prod2 = 32'h7FFF_FFFF; in_last2 = (i == 2);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid2 = 1'b0; in_last2 = 1'b0;
    checks++;
    if (out_valid2 !== 1'b1 || out_acc2 !== exp_acc || out_count2 !== 5'd3 || out_ovf2 !== 1'b1) begin
      errors++;
      $display("FAIL overflow: valid=%b acc=%h cnt=%0d ovf=%b, want 1 %h 3 1",
               out_valid2, out_acc2, out_count2, out_ovf2, exp_acc);
    end
    out_ready2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready2 = 1'b0;
    checks++;
    if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin
      errors++;
      $display("FAIL overflow_release: valid=%b ready=%b, want 0 1", out_valid2, in_ready2);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_prod = 32'd0; in_last = 1'b0; out_ready = 1'b0;
    in_valid2 = 1'b0; in_prod2 = 32'd0; in_last2 = 1'b0; out_ready2 = 1'b0;
    test_reset();
    test_basic_frame();
    test_max_terms();
    test_stall();
    test_reset_mid_frame();
    test_single_term();
    test_negative();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
